// File: rtl/code_detector.sv
// code_detector: four-button combination lock with a single 7-segment readout.
// Collects four button presses and compares them against CODE0..CODE3.
// The digit shows progress 0..3, then "U" (unlocked) or "E" (error).
// Optional build macro AUTO_CLEAR_EN: OPEN/ERROR return to IDLE after
// CLEAR_CYCLES clock cycles. Without it they hold until buttonReset.
module code_detector #(
  parameter logic [1:0]  CODE0        = 2'd0,
  parameter logic [1:0]  CODE1        = 2'd2,
  parameter logic [1:0]  CODE2        = 2'd2,
  parameter logic [1:0]  CODE3        = 2'd3,
  parameter logic [31:0] CLEAR_CYCLES = 32'd100
) (
  input  logic       clk,
  input  logic       buttonReset,
  input  logic       buttonTop,
  input  logic       buttonDown,
  input  logic       buttonLeft,
  input  logic       buttonRight,
  output logic [6:0] SSG_D
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_P1    = 3'd1,
    ST_P2    = 3'd2,
    ST_P3    = 3'd3,
    ST_OPEN  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_E = 7'b0000110;

  state_t     state;
  state_t     state_next;
  logic       mismatch;
  logic       mismatch_next;

  // Bit index equals the symbol encoding: 0=Top, 1=Down, 2=Left, 3=Right.
  logic [3:0] buttons;
  logic [3:0] prev;
  logic [3:0] press;
  logic       press_any;
  logic       press_multi;
  logic [1:0] symbol;
  logic [1:0] expected_sym;
  logic       sym_bad;

`ifdef AUTO_CLEAR_EN
  logic [31:0] hold_cnt;
  logic [31:0] hold_cnt_next;
`endif

  assign buttons     = {buttonRight, buttonLeft, buttonDown, buttonTop};
  assign press       = buttons & ~prev;
  assign press_any   = |press;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign press_multi = (press & (press - 4'd1)) != 4'd0;
  // A simultaneous press can never match a single code symbol.
  assign sym_bad     = press_multi | (symbol != expected_sym);

  // Previous button levels; during reset this also captures held buttons so
  // their release after reset is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    prev <= buttons;
  end

  // Encode the pressed button into its symbol (only meaningful for one press).
  always_comb begin
    symbol = 2'd0;
    if (press[3])      symbol = 2'd3;
    else if (press[2]) symbol = 2'd2;
    else if (press[1]) symbol = 2'd1;
    else               symbol = 2'd0;
  end

  // Select the code symbol that the press leaving the current state must match.
  always_comb begin
    expected_sym = CODE0;
    case (state)
      ST_IDLE: expected_sym = CODE0;
      ST_P1:   expected_sym = CODE1;
      ST_P2:   expected_sym = CODE2;
      ST_P3:   expected_sym = CODE3;
      default: expected_sym = CODE0;
    endcase
  end

  // Next-state logic: one state per press, sticky mismatch, verdict on 4th press.
  always_comb begin
    state_next    = state;
    mismatch_next = mismatch;
`ifdef AUTO_CLEAR_EN
    hold_cnt_next = hold_cnt;
`endif
    case (state)
      ST_IDLE: begin
        // A fresh entry starts with a clean flag, whatever the previous result.
        if (press_any) begin
          mismatch_next = sym_bad;
          state_next    = ST_P1;
        end
      end
      ST_P1: begin
        if (press_any) begin
          mismatch_next = mismatch | sym_bad;
          state_next    = ST_P2;
        end
      end
      ST_P2: begin
        if (press_any) begin
          mismatch_next = mismatch | sym_bad;
          state_next    = ST_P3;
        end
      end
      ST_P3: begin
        if (press_any) begin
          mismatch_next = mismatch | sym_bad;
          state_next    = (mismatch | sym_bad) ? ST_ERROR : ST_OPEN;
`ifdef AUTO_CLEAR_EN
          hold_cnt_next = CLEAR_CYCLES;
`endif
        end
      end
      ST_OPEN, ST_ERROR: begin
        // Presses are ignored here; only the hold timer (if built) or reset leaves.
`ifdef AUTO_CLEAR_EN
        if (hold_cnt <= 32'd1) begin
          hold_cnt_next = 32'd0;
          state_next    = ST_IDLE;
        end else begin
          hold_cnt_next = hold_cnt - 32'd1;
        end
`endif
      end
      default: begin
        state_next    = ST_IDLE;
        mismatch_next = 1'b0;
      end
    endcase
  end

  // State, mismatch flag and hold counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (buttonReset) begin
      state    <= ST_IDLE;
      mismatch <= 1'b0;
`ifdef AUTO_CLEAR_EN
      hold_cnt <= 32'd0;
`endif
    end else begin
      state    <= state_next;
      mismatch <= mismatch_next;
`ifdef AUTO_CLEAR_EN
      hold_cnt <= hold_cnt_next;
`endif
    end
  end

  // Active-low 7-segment decode of the state register.
  always_comb begin
    SSG_D = SEG_0;
    case (state)
      ST_IDLE:  SSG_D = SEG_0;
      ST_P1:    SSG_D = SEG_1;
      ST_P2:    SSG_D = SEG_2;
      ST_P3:    SSG_D = SEG_3;
      ST_OPEN:  SSG_D = SEG_U;
      ST_ERROR: SSG_D = SEG_E;
      default:  SSG_D = SEG_0;
    endcase
  end

endmodule

// File: tb/tb_code_detector.sv
// tb_code_detector: scoreboard bench for code_detector.
// Expected digit codes are queued as each cycle's stimulus is driven and
// popped/compared one time unit after the following rising clock edge.
// With AUTO_CLEAR_EN defined the DUT is built with CLEAR_CYCLES=4.
`timescale 1ns/1ps
module tb_code_detector;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_U = 7'b1000001;
  localparam logic [6:0] SEG_E = 7'b0000110;

  // Button masks: bit0=Top, bit1=Down, bit2=Left, bit3=Right.
  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_T    = 4'b0001;
  localparam logic [3:0] B_D    = 4'b0010;
  localparam logic [3:0] B_L    = 4'b0100;
  localparam logic [3:0] B_R    = 4'b1000;

`ifdef AUTO_CLEAR_EN
  localparam logic [31:0] CLR = 32'd4;
`else
  localparam logic [31:0] CLR = 32'd100;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [6:0] seg;

  logic [6:0] exp_q[$];
  logic [6:0] got;
  logic [6:0] want;
  int         checks   = 0;
  int         failures = 0;

  code_detector #(
    .CLEAR_CYCLES(CLR)
  ) dut (
    .clk         (clk),
    .buttonReset (rst),
    .buttonTop   (btn[0]),
    .buttonDown  (btn[1]),
    .buttonLeft  (btn[2]),
    .buttonRight (btn[3]),
    .SSG_D       (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of button levels, queue its expected digit, then wait
  // until just after the edge that consumes it.
  task automatic drive_cycle(input logic [3:0] mask, input logic [6:0] exp_seg);
    @(negedge clk);
    btn = mask;
    exp_q.push_back(exp_seg);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = B_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] m [0:3];
    logic [6:0] e [0:3];
    m = '{B_L, B_L, B_NONE, B_T};
    e = '{SEG_0, SEG_0, SEG_0, SEG_1};
    @(negedge clk);
    rst = 1'b1;
    btn = B_L;
    exp_q.push_back(SEG_0);
    repeat (3) @(posedge clk);
    #1;
    got = seg; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_value: SSG_D=%b expected %b", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    // Left stays held past reset release: must not count as a press.
    for (int i = 0; i < 4; i++) begin
      drive_cycle(m[i], e[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_held step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_correct_code();
    logic [3:0] m [0:7];
    logic [6:0] e [0:7];
    m = '{B_T, B_NONE, B_L, B_NONE, B_L, B_NONE, B_R, B_NONE};
    e = '{SEG_1, SEG_1, SEG_2, SEG_2, SEG_3, SEG_3, SEG_U, SEG_U};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(m[i], e[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL correct_code step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_wrong_code();
    logic [3:0] m [0:7];
    logic [6:0] e [0:7];
    m = '{B_T, B_NONE, B_R, B_NONE, B_L, B_NONE, B_R, B_NONE};
    e = '{SEG_1, SEG_1, SEG_2, SEG_2, SEG_3, SEG_3, SEG_E, SEG_E};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(m[i], e[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL wrong_code step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_hold();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle((i < 5) ? B_L : B_NONE, SEG_1);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL hold step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] m [0:7];
    logic [6:0] e [0:7];
    m = '{B_T | B_L, B_NONE, B_L, B_NONE, B_L, B_NONE, B_R, B_NONE};
    e = '{SEG_1, SEG_1, SEG_2, SEG_2, SEG_3, SEG_3, SEG_E, SEG_E};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(m[i], e[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL simultaneous step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] m [0:3];
    logic [6:0] e [0:3];
    logic [3:0] c [0:7];
    logic [6:0] ce [0:7];
    m  = '{B_T, B_NONE, B_L, B_NONE};
    e  = '{SEG_1, SEG_1, SEG_2, SEG_2};
    c  = '{B_T, B_NONE, B_L, B_NONE, B_L, B_NONE, B_R, B_NONE};
    ce = '{SEG_1, SEG_1, SEG_2, SEG_2, SEG_3, SEG_3, SEG_U, SEG_U};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(m[i], e[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mid_reset_partial step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    btn = B_NONE;
    exp_q.push_back(SEG_0);
    @(posedge clk);
    #1;
    got = seg; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL mid_reset_clear: SSG_D=%b expected %b", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(c[i], ce[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mid_reset_reentry step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask

`ifdef AUTO_CLEAR_EN
  task automatic test_auto_clear();
    logic [3:0] m [0:7];
    logic [6:0] e [0:7];
    // "U" appears at the R press edge, then three more "U" cycles (a press is
    // ignored during the hold), then IDLE, then a new entry is accepted.
    m = '{B_R, B_T, B_NONE, B_NONE, B_NONE, B_T, B_NONE, B_L};
    e = '{SEG_U, SEG_U, SEG_U, SEG_U, SEG_0, SEG_1, SEG_1, SEG_2};
    apply_reset();
    drive_cycle(B_T, SEG_1);
    void'(exp_q.pop_front());
    drive_cycle(B_L, SEG_2);
    void'(exp_q.pop_front());
    drive_cycle(B_NONE, SEG_2);
    void'(exp_q.pop_front());
    drive_cycle(B_L, SEG_3);
    void'(exp_q.pop_front());
    drive_cycle(B_NONE, SEG_3);
    got = seg; want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL auto_clear_setup: SSG_D=%b expected %b", got, want);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(m[i], e[i]);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL auto_clear step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask
`else
  task automatic test_terminal();
    logic [3:0] m [0:5];
    m = '{B_T, B_NONE, B_D, B_NONE, B_T | B_R, B_NONE};
    // Continues from the "U" left by test_mid_reset.
    for (int i = 0; i < 6; i++) begin
      drive_cycle(m[i], SEG_U);
      got = seg; want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL terminal_open step %0d: SSG_D=%b expected %b", i, got, want);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_hold();
    test_simultaneous();
    test_mid_reset();
`ifdef AUTO_CLEAR_EN
    test_auto_clear();
`else
    test_terminal();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
